alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the execute-stage ALU.
- Accepts one operation per valid/ready handshake and holds the result until consumed.
- Single-cycle ops: AND, OR, XOR, ADDS, ADDU, SUBS, SUBU, SHRL, SHLL, SHRA.
- Multi-cycle ops (compile-option): MULU, DIVU, REMU, using an iterative shift-add / restoring datapath.
- Sits between decode/issue and the EX/MEM pipeline register; stalls issue via InReady.

Parameters:
- DATA_W, 32, operand/result width (power of two, >= 8).
- SHAMT_W, $clog2(DATA_W), shift-amount bits taken from In1[SHAMT_W-1:0].

Ports:
- Clk  in  1  clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  operands/op valid.
- InReady  out  1  block can accept this cycle.
- In0  in  DATA_W  operand A.
- In1  in  DATA_W  operand B / shift amount.
- Op  in  4  operation code.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts result.
- Out  out  DATA_W  result.
- OF  out  1  signed overflow (ADDS/SUBS only).
- DZ  out  1  divide by zero (DIVU/REMU only).

Behaviour:
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 ADDS, 4 ADDU, 5 SUBS, 6 SUBU, 7 SHRL, 8 SHLL, 9 SHRA, 10 MULU, 11 DIVU, 12 REMU. Codes 13-15 give Out=In0, OF=0, DZ=0, single-cycle.
- Handshake: accept when InValid && InReady. Result is delivered when OutValid && OutReady.
- InReady = (State==IDLE) || (State==DONE && OutReady). Back-to-back issue is allowed on result consumption.
- States:
  - IDLE: on accept of a single-cycle op -> DONE, with Out/OF/DZ registered at the same edge (latency 1). On accept of MULU/DIVU/REMU -> BUSY, iteration counter = DATA_W-1.
  - BUSY: one iteration per cycle; counter decrements. At counter==0, the final result is registered -> DONE. Latency = DATA_W+1 cycles from accept to OutValid. InReady=0.
  - DONE: OutValid=1; Out/OF/DZ stable until handshake. On OutReady: if a new accept occurs in the same cycle -> DONE or BUSY per the new op, else -> IDLE.
- Arithmetic: all add/sub results are modulo 2^DATA_W.
- OF, ADDS: set when sign(In0)==sign(In1) and sign(result)!=sign(In0).
- OF, SUBS: set when sign(In0)!=sign(In1) and sign(result)!=sign(In0).
- OF is 0 for all other ops; it is never left unassigned.
- Shifts use In1[SHAMT_W-1:0] only; SHRA replicates In0[DATA_W-1].
- MULU returns the low DATA_W bits of the unsigned product.
- DIVU/REMU are unsigned. Divisor 0: quotient = all ones, remainder = In0, DZ=1, same latency as a normal divide.
- Operands are captured at accept; later changes on In0/In1/Op have no effect.
- Reset (any state, including mid-BUSY): State=IDLE, OutValid=0, Out=0, OF=0, DZ=0, counter=0. Any in-flight op is discarded. InReady=1 in the cycle after reset deasserts.
- InValid while BUSY is ignored; the producer holds it.

Optional Feature:
- Macro: ALU_MUL_DIV_EN.
- Defined: MULU/DIVU/REMU are implemented as above; BUSY state and counter exist.
- Undefined: no BUSY state or iterative datapath. Ops 10-12 behave as codes 13-15 (Out=In0, OF=0, DZ=0, latency 1). DZ is tied 0.

Test Plan:
- Reset, then ADDS In0=0x7FFFFFFF, In1=0x00000001, OutReady=1 -> next cycle OutValid=1, Out=0x80000000, OF=1; following cycle OutValid=0.
- SUBS 0x80000000 - 0x00000001, then SHRA 0x80000000 by In1=0x21 (uses 1) -> Out=0x7FFFFFFF, OF=1; then Out=0xC0000000, OF=0. Back-to-back issue with InReady held 1.
- With ALU_MUL_DIV_EN: MULU 0x00010003 * 0x00020005 -> Out=0x000B000F after 33 cycles; InReady=0 throughout BUSY.
- With ALU_MUL_DIV_EN: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> Out=0xFFFFFFFF, DZ=1; REMU 5/0 -> Out=5, DZ=1.
- Backpressure: OutReady=0 for 5 cycles after AND 0xF0F0F0F0 & 0xFF00FF00 -> Out=0xF000F000 held stable, InReady=0; OutReady=1 plus new InValid in the same cycle -> both accepted.
- Assert Reset at BUSY cycle 10 of DIVU -> next cycle OutValid=0, Out=0, InReady=1; a subsequent XOR 0xAAAA5555 ^ 0xFFFF0000 -> Out=0x55555555.

Source files
------------

// File: rtl/alu_seq.sv
// Registered, handshaked execute-stage ALU with single-cycle logic/arith/shift ops.
// Define ALU_MUL_DIV_EN to add iterative MULU/DIVU/REMU (shift-add / restoring divide).
module alu_seq #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] In0,
    input  logic [DATA_W-1:0] In1,
    input  logic [3:0]        Op,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] Out,
    output logic              OF,
    output logic              DZ
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_ADDS = 4'd3;
    localparam logic [3:0] OP_ADDU = 4'd4;
    localparam logic [3:0] OP_SUBS = 4'd5;
    localparam logic [3:0] OP_SUBU = 4'd6;
    localparam logic [3:0] OP_SHRL = 4'd7;
    localparam logic [3:0] OP_SHLL = 4'd8;
    localparam logic [3:0] OP_SHRA = 4'd9;

`ifdef ALU_MUL_DIV_EN
    localparam logic [3:0] OP_MULU = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;
    localparam int         CNT_W   = SHAMT_W;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t state, stateNext;

    logic              accept;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0] aluRes;
    logic              aluOf;
    logic [DATA_W-1:0] outReg;
    logic              ofReg;

    assign InReady  = (state == IDLE) || ((state == DONE) && OutReady);
    assign accept   = InValid && InReady;
    assign OutValid = (state == DONE);
    assign Out      = outReg;
    assign OF       = ofReg;

    assign sum   = In0 + In1;
    assign diff  = In0 - In1;
    assign shamt = In1[SHAMT_W-1:0];

    always_comb begin
        aluRes = In0;
        aluOf  = 1'b0;
        case (Op)
            OP_AND:  aluRes = In0 & In1;
            OP_OR:   aluRes = In0 | In1;
            OP_XOR:  aluRes = In0 ^ In1;
            OP_ADDS: begin
                aluRes = sum;
                aluOf  = (In0[DATA_W-1] == In1[DATA_W-1]) && (sum[DATA_W-1] != In0[DATA_W-1]);
            end
            OP_ADDU: aluRes = sum;
            OP_SUBS: begin
                aluRes = diff;
                aluOf  = (In0[DATA_W-1] != In1[DATA_W-1]) && (diff[DATA_W-1] != In0[DATA_W-1]);
            end
            OP_SUBU: aluRes = diff;
            OP_SHRL: aluRes = In0 >> shamt;
            OP_SHLL: aluRes = In0 << shamt;
            OP_SHRA: aluRes = $unsigned($signed(In0) >>> shamt);
            default: aluRes = In0;
        endcase
    end

`ifdef ALU_MUL_DIV_EN
    logic              isMulti;
    logic              lastIter;
    logic [CNT_W-1:0]  counter;
    logic [3:0]        opReg;
    logic [DATA_W-1:0] aReg;
    logic [DATA_W-1:0] bReg;
    logic [DATA_W-1:0] accReg;
    logic              dzReg;
    logic [DATA_W:0]   divShift;
    logic [DATA_W:0]   divTrial;
    logic [DATA_W-1:0] aNext;
    logic [DATA_W-1:0] bNext;
    logic [DATA_W-1:0] accNext;
    logic [DATA_W-1:0] finalRes;

    assign isMulti  = (Op == OP_MULU) || (Op == OP_DIVU) || (Op == OP_REMU);
    assign lastIter = (state == BUSY) && (counter == '0);
    assign DZ       = dzReg;

    // MULU: acc += mcand when multiplier LSB set. DIVU/REMU: aReg shifts the dividend out
    // and quotient bits in, accReg is the partial remainder (zero divisor yields all-ones/In0).
    always_comb begin
        divShift = {accReg, aReg[DATA_W-1]};
        divTrial = divShift - {1'b0, bReg};
        aNext    = aReg;
        bNext    = bReg;
        accNext  = accReg;
        if (opReg == OP_MULU) begin
            accNext = accReg + (bReg[0] ? aReg : '0);
            aNext   = aReg << 1;
            bNext   = bReg >> 1;
        end else if (!divTrial[DATA_W]) begin
            accNext = divTrial[DATA_W-1:0];
            aNext   = {aReg[DATA_W-2:0], 1'b1};
        end else begin
            accNext = divShift[DATA_W-1:0];
            aNext   = {aReg[DATA_W-2:0], 1'b0};
        end
        finalRes = (opReg == OP_DIVU) ? aNext : accNext;
    end
`else
    assign DZ = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A consumed result with a new op pending re-enters DONE/BUSY directly.
    always_comb begin
        stateNext = state;
        if (accept) begin
`ifdef ALU_MUL_DIV_EN
            stateNext = isMulti ? BUSY : DONE;
`else
            stateNext = DONE;
`endif
        end else begin
            case (state)
`ifdef ALU_MUL_DIV_EN
                BUSY: if (lastIter) stateNext = DONE;
`endif
                DONE: if (OutReady) stateNext = IDLE;
                default: stateNext = state;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            outReg  <= '0;
            ofReg   <= 1'b0;
`ifdef ALU_MUL_DIV_EN
            dzReg   <= 1'b0;
            counter <= '0;
            opReg   <= '0;
            aReg    <= '0;
            bReg    <= '0;
            accReg  <= '0;
`endif
        end else if (accept) begin
`ifdef ALU_MUL_DIV_EN
            if (isMulti) begin
                opReg   <= Op;
                aReg    <= In0;
                bReg    <= In1;
                accReg  <= '0;
                counter <= CNT_W'(DATA_W - 1);
            end else begin
                outReg <= aluRes;
                ofReg  <= aluOf;
                dzReg  <= 1'b0;
            end
`else
            outReg <= aluRes;
            ofReg  <= aluOf;
`endif
        end
`ifdef ALU_MUL_DIV_EN
        else if (state == BUSY) begin
            aReg    <= aNext;
            bReg    <= bNext;
            accReg  <= accNext;
            counter <= counter - CNT_W'(1);
            if (counter == '0) begin
                outReg <= finalRes;
                ofReg  <= 1'b0;
                dzReg  <= (opReg != OP_MULU) && (bReg == '0);
            end
        end
`endif
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table plus hand sequences, scoreboard-checked results.
// Multi-cycle checks run when ALU_MUL_DIV_EN is defined; otherwise ops 10-12 act as pass-through.
module tb_alu_seq;

    localparam int DATA_W = 32;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              InValid;
    logic              InReady;
    logic [DATA_W-1:0] In0;
    logic [DATA_W-1:0] In1;
    logic [3:0]        Op;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] Out;
    logic              OF;
    logic              DZ;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expOut;
        logic        expOf;
        logic        expDz;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic        of;
        logic        dz;
    } exp_t;

    exp_t scoreboard[$];
    vec_t vecs[$];
    vec_t multiVecs[$];
    int   assertions = 0;
    int   failures   = 0;

    alu_seq #(.DATA_W(DATA_W)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .In0(In0), .In1(In1), .Op(Op), .OutValid(OutValid), .OutReady(OutReady),
        .Out(Out), .OF(OF), .DZ(DZ)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    function automatic vec_t mkVec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] expOut, input logic expOf, input logic expDz);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.expOut = expOut; v.expOf = expOf; v.expDz = expDz;
        return v;
    endfunction

    // Called at a negedge; holds the op until accepted, then scrambles the operand inputs.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expOut, input logic expOf, input logic expDz,
                                 input bit push, output int waited);
        exp_t e;
        Op = op; In0 = a; In1 = b; InValid = 1'b1;
        #1;
        waited = 0;
        while (InReady !== 1'b1 && waited < 200) begin
            @(negedge Clk);
            #1;
            waited++;
        end
        if (InReady !== 1'b1) begin
            assertions++;
            failures++;
            $display("[TB] FAIL accept_timeout: InReady got %b required 1", InReady);
            InValid = 1'b0;
            return;
        end
        if (push) begin
            e.out = expOut; e.of = expOf; e.dz = expDz;
            scoreboard.push_back(e);
        end
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        In0 = ~a;
        In1 = ~b;
        Op  = ~op;
    endtask

    task automatic waitResult(output int lat, output bit readyLow);
        lat = 1;
        readyLow = 1'b1;
        @(negedge Clk);
        while (OutValid !== 1'b1 && lat < 200) begin
            if (InReady !== 1'b0) readyLow = 1'b0;
            @(negedge Clk);
            lat++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            #2;
            if (OutValid === 1'b1 && OutReady === 1'b1) begin
                if (scoreboard.size() == 0) begin
                    assertions++;
                    failures++;
                    $display("[TB] FAIL unexpected_result: got 0x%08h with no expected entry", Out);
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput("sb_out", Out, e.out);
                    checkBit("sb_of", OF, e.of);
                    checkBit("sb_dz", DZ, e.dz);
                end
            end
        end
    end

    initial begin : main
        int  w;
        int  lat;
        int  n;
        bit  rl;
        bit  vld;
        bit  hold;

        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b1; In0 = '0; In1 = '0; Op = '0;

        vecs.push_back(mkVec(4'd5,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0));
        vecs.push_back(mkVec(4'd9,  32'h80000000, 32'h00000021, 32'hC0000000, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd1,  32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd2,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd4,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd6,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd7,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd8,  32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd9,  32'h40000000, 32'h00000002, 32'h10000000, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd3,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0));
        vecs.push_back(mkVec(4'd3,  32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd3,  32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd5,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0));
        vecs.push_back(mkVec(4'd5,  32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd4,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd13, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd15, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0));
`ifndef ALU_MUL_DIV_EN
        vecs.push_back(mkVec(4'd10, 32'hCAFEF00D, 32'h00000003, 32'hCAFEF00D, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd11, 32'h00000005, 32'h00000000, 32'h00000005, 1'b0, 1'b0));
        vecs.push_back(mkVec(4'd12, 32'h00000064, 32'h00000007, 32'h00000064, 1'b0, 1'b0));
`else
        multiVecs.push_back(mkVec(4'd11, 32'd100,       32'd7,        32'd14,       1'b0, 1'b0));
        multiVecs.push_back(mkVec(4'd12, 32'd100,       32'd7,        32'd2,        1'b0, 1'b0));
        multiVecs.push_back(mkVec(4'd11, 32'd5,         32'd0,        32'hFFFFFFFF, 1'b0, 1'b1));
        multiVecs.push_back(mkVec(4'd12, 32'd5,         32'd0,        32'd5,        1'b0, 1'b1));
        multiVecs.push_back(mkVec(4'd10, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0));
        multiVecs.push_back(mkVec(4'd11, 32'hFFFFFFFF,  32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0));
        multiVecs.push_back(mkVec(4'd12, 32'hFFFFFFFF,  32'h00000010, 32'h0000000F, 1'b0, 1'b0));
        multiVecs.push_back(mkVec(4'd11, 32'h00000003,  32'h00000009, 32'h00000000, 1'b0, 1'b0));
`endif

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkBit("reset_outvalid", OutValid, 1'b0);
        checkOutput("reset_out", Out, 32'h0);
        checkBit("reset_of", OF, 1'b0);
        checkBit("reset_dz", DZ, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);
        checkBit("ready_after_reset", InReady, 1'b1);

        applyStimulus(4'd3, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b1, w);
        @(negedge Clk);
        checkBit("adds_latency1", OutValid, 1'b1);
        @(negedge Clk);
        checkBit("adds_outvalid_drop", OutValid, 1'b0);

        $display("[TB] applying %0d table vectors back-to-back", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clk);
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expOut, vecs[i].expOf,
                          vecs[i].expDz, 1'b1, w);
            if (i > 0) checkOutput($sformatf("back2back_wait_%0d", i), w, 0);
        end
        repeat (2) @(negedge Clk);

`ifdef ALU_MUL_DIV_EN
        applyStimulus(4'd10, 32'h00010003, 32'h00020005, 32'h000B000F, 1'b0, 1'b0, 1'b1, w);
        waitResult(lat, rl);
        checkOutput("mulu_latency", lat, DATA_W + 1);
        checkBit("mulu_busy_inready_low", rl, 1'b1);
        for (int i = 0; i < multiVecs.size(); i++) begin
            @(negedge Clk);
            applyStimulus(multiVecs[i].op, multiVecs[i].a, multiVecs[i].b, multiVecs[i].expOut,
                          multiVecs[i].expOf, multiVecs[i].expDz, 1'b1, w);
            waitResult(lat, rl);
            checkOutput($sformatf("multi_latency_%0d", i), lat, DATA_W + 1);
            checkBit($sformatf("multi_busy_inready_low_%0d", i), rl, 1'b1);
        end
        repeat (2) @(negedge Clk);
`endif

        OutReady = 1'b0;
        applyStimulus(4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b1, w);
        vld = 1'b1; hold = 1'b1; rl = 1'b1;
        repeat (5) begin
            @(negedge Clk);
            if (OutValid !== 1'b1) vld = 1'b0;
            if (Out !== 32'hF000F000) hold = 1'b0;
            if (InReady !== 1'b0) rl = 1'b0;
        end
        checkBit("bp_outvalid_held", vld, 1'b1);
        checkBit("bp_out_stable", hold, 1'b1);
        checkBit("bp_inready_low", rl, 1'b0 ^ 1'b1);
        OutReady = 1'b1;
        applyStimulus(4'd1, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 1'b0, 1'b0, 1'b1, w);
        checkOutput("bp_simultaneous_accept_wait", w, 0);
        repeat (2) @(negedge Clk);

        OutReady = 1'b0;
        applyStimulus(4'd11, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0, w);
        repeat (10) @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        OutReady = 1'b1;
        @(negedge Clk);
        checkBit("midop_reset_outvalid", OutValid, 1'b0);
        checkOutput("midop_reset_out", Out, 32'h0);
        checkBit("midop_reset_dz", DZ, 1'b0);
        checkBit("midop_reset_inready", InReady, 1'b1);
        applyStimulus(4'd2, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 1'b1, w);
        checkOutput("post_reset_accept_wait", w, 0);

        n = 0;
        while (scoreboard.size() != 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
        checkOutput("scoreboard_drained", scoreboard.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
